// File: rtl/func_sweep_ctrl_pkg.sv
// Shared constants for the boolean-function sweep controller: state encoding
// and default sizing.
package func_sweep_ctrl_pkg;

    localparam int N_IN_DEF   = 4;
    localparam int N_IMPL_DEF = 3;
    localparam int SETTLE_DEF = 1;
    localparam int CNT_W      = 4;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/func_sweep_ctrl_if.sv
// Bundle between the sweep controller and its host / the function instances.
interface func_sweep_ctrl_if
    import func_sweep_ctrl_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int N_IMPL = N_IMPL_DEF
);
    logic                 start;
    logic [N_IN-1:0]      vec_out;
    logic [N_IMPL-1:0]    y_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [N_IN:0]        err_cnt;
    logic                 first_fail_valid;
    logic [N_IN-1:0]      first_fail_vec;
    logic [2**N_IN-1:0]   truth;

    modport master (
        output start, y_in,
        input  vec_out, busy, done, pass, err_cnt,
               first_fail_valid, first_fail_vec, truth
    );

    modport slave (
        input  start, y_in,
        output vec_out, busy, done, pass, err_cnt,
               first_fail_valid, first_fail_vec, truth
    );
endinterface

// File: rtl/func_sweep_ctrl_sweep_cmp.sv
// N-way agreement checker: flags any implementation output that differs
// from the golden reference in bit 0.
module sweep_cmp #(
    parameter int N_IMPL = 3
) (
    input  logic [N_IMPL-1:0] y,
    output logic              mismatch
);
    assign mismatch = (y != {N_IMPL{y[0]}});
endmodule

// File: rtl/func_sweep_ctrl.sv
// Self-test sequencer: steps a shared vector through every input combination,
// settles, then compares all implementation outputs and records the results.
module func_sweep_ctrl
    import func_sweep_ctrl_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int N_IMPL = N_IMPL_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    func_sweep_ctrl_if.slave bus
);
    localparam int                N_VEC     = 2**N_IN;
    localparam logic [N_IN:0]     ERR_MAX   = (N_IN+1)'(N_VEC);
    localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE);

    state_t               state;
    logic [CNT_W-1:0]     settle_cnt;
    logic [N_IN-1:0]      vec;
    logic                 done;
    logic                 pass;
    logic [N_IN:0]        err_cnt;
    logic [N_IN:0]        err_next;
    logic                 ff_valid;
    logic [N_IN-1:0]      ff_vec;
    logic [N_VEC-1:0]     truth;
    logic                 mismatch;

    sweep_cmp #(.N_IMPL(N_IMPL)) u_cmp (
        .y        (bus.y_in),
        .mismatch (mismatch)
    );

    // Saturating count so the all-vectors-failing case cannot wrap to zero.
    always_comb begin
        err_next = err_cnt;
        if (mismatch && (err_cnt != ERR_MAX))
            err_next = err_cnt + (N_IN+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            vec        <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            ff_valid   <= 1'b0;
            ff_vec     <= '0;
            truth      <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state      <= ST_WAIT;
                        settle_cnt <= SETTLE_LD;
                        vec        <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_cnt    <= '0;
                        ff_valid   <= 1'b0;
                        ff_vec     <= '0;
                        truth      <= '0;
                    end
                end
                ST_WAIT: begin
                    settle_cnt <= settle_cnt - CNT_W'(1);
                    if (settle_cnt <= CNT_W'(1))
                        state <= ST_CHECK;
                end
                ST_CHECK: begin
                    truth[vec] <= bus.y_in[0];
                    err_cnt    <= err_next;
                    if (mismatch && !ff_valid) begin
                        ff_valid <= 1'b1;
                        ff_vec   <= vec;
                    end
                    if (&vec) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        state      <= ST_WAIT;
                        vec        <= vec + N_IN'(1);
                        settle_cnt <= SETTLE_LD;
                    end
                end
            endcase
        end
    end

    assign bus.vec_out          = vec;
    assign bus.busy             = (state == ST_WAIT) || (state == ST_CHECK);
    assign bus.done             = done;
    assign bus.pass             = pass;
    assign bus.err_cnt          = err_cnt;
    assign bus.first_fail_valid = ff_valid;
    assign bus.first_fail_vec   = ff_vec;
    assign bus.truth            = truth;
endmodule

// File: doc/func_sweep_ctrl.md
Name: func_sweep_ctrl

Overview:
Hardware sweep controller for the 4-input boolean-function implementations (dataflow, single-mux and two-mux variants). It steps a shared input vector through every combination, waits a settle time, then samples all implementation outputs and checks that they agree. It records the truth table of implementation 0, the mismatch count and the first failing vector. The block sits above the function instances as their on-board self-test sequencer.

Parameters:
N_IN, 4, number of function inputs; the sweep covers 2**N_IN vectors
N_IMPL, 3, number of implementations compared (y_in width)
SETTLE, 1, cycles the vector is held before sampling; legal range is 1..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a sweep
vec_out  output  N_IN  shared input vector {A,B,C,D}; MSB = A
y_in  input  N_IMPL  implementation outputs; bit 0 is the golden reference
busy  output  1  high while a sweep is running
done  output  1  high from end of sweep until the next accepted start
pass  output  1  valid while done; 1 when err_cnt == 0
err_cnt  output  N_IN+1  number of vectors with any disagreement; saturates at 2**N_IN
first_fail_valid  output  1  set on the first mismatch of a sweep
first_fail_vec  output  N_IN  vector of the first mismatch
truth  output  2**N_IN  truth[v] = y_in[0] sampled at vector v

Behaviour:
- Reset is asynchronous and active-high. On reset the state goes to IDLE and every output is 0: vec_out, busy, done, pass, err_cnt, first_fail_valid, first_fail_vec and truth.
- States are IDLE, WAIT, CHECK and DONE. The block also holds a settle counter (width 4) and a vector register.
- IDLE or DONE with start=1: on the next edge, clear err_cnt, first_fail_*, truth, done and pass. Set vec_out to 0, load the settle counter with SETTLE, and go to WAIT. busy rises in the same cycle.
- WAIT: decrement the settle counter each cycle. When it reaches 1, go to CHECK on the next edge. The vector is therefore held for exactly SETTLE cycles before CHECK.
- CHECK lasts one cycle and samples y_in.
  - Write truth[vec_out] with y_in[0].
  - A mismatch is any y_in bit that differs from y_in[0]. On a mismatch, increment err_cnt.
  - On a mismatch with first_fail_valid=0, latch first_fail_vec = vec_out and set first_fail_valid.
  - If vec_out is all ones: go to DONE, drop busy, set done=1 and set pass = (updated err_cnt == 0). These updates occur on the same edge.
  - Otherwise: increment vec_out, reload the settle counter with SETTLE, and go to WAIT.
- Per-vector cost is SETTLE+1 cycles. Total sweep is 2**N_IN*(SETTLE+1) cycles from the start-accept edge to the done-rise edge, which is 32 cycles at the defaults.
- DONE holds all results and vec_out (all ones) until the next start.
- start is ignored while busy. A start held for several cycles in DONE triggers exactly one new sweep.
- The vector counter never wraps mid-sweep; the all-ones check terminates the sweep before it can.
- Reset mid-sweep aborts immediately. All outputs return to their reset values, including partial results.

Decomposition:
- Shared package holds the state encoding (IDLE=0, WAIT=1, CHECK=2, DONE=3) and the default N_IN, N_IMPL and SETTLE constants.
- One natural sub-module, sweep_cmp: a combinational N_IMPL-way agreement checker that outputs a mismatch flag. The FSM, counters and result registers stay in the top module.

Test Plan:
1. Clean sweep. Defaults; bench drives y_in = {3{f(vec)}} with f truth table 16'hB2C4; start at t0. Required: done rises exactly 32 cycles later, pass=1, err_cnt=0, first_fail_valid=0, truth=16'hB2C4.
2. Single fault. Same as scenario 1, but y_in[2] is forced to 0 at vec=5 (f(5)=0 would mask the fault, so use vec=6 where f=1). Required: err_cnt=1, first_fail_vec=6, first_fail_valid=1, pass=0, truth still 16'hB2C4.
3. Total fault. y_in[1] is always the complement of f. Required: err_cnt=16 (saturation bound reached, no overflow), first_fail_vec=0, pass=0.
4. start while busy. Pulse start at cycles 5 and 10 of a sweep. Required: done timing unchanged (32 cycles from the first accept), and no restart.
5. Reset mid-sweep. Assert rst while vec_out=7 with err_cnt=1. Required: all outputs 0 immediately (asynchronously), state IDLE. A later start gives a full clean sweep.
6. Settle time. SETTLE=3 with the clean stimulus. Required: each vector is held for 4 cycles, done arrives 64 cycles after start, and a re-start from DONE clears previous results in the accept cycle.
